// File: rtl/pillars_multi_obstacle.sv
// Scrolling multi-pillar obstacle: overlays vertical pillars on the pixel stream, pulses done after WAVES respawns.
// Latency: 1 cycle pixel in to pixel out in every state; no backpressure, the pixel stream is never stalled.
module pillars_multi_obstacle #(
    parameter logic [3:0]  SELECT_CODE   = 4'b0000,
    parameter int          PILLAR_COUNT  = 2,
    parameter int          PILLAR_WIDTH  = 21,
    parameter int          SPACING       = 160,
    parameter int          DX            = 1,
    parameter int          FRAME_DIV     = 600,
    parameter int          WAVES         = 10,
    parameter int          DIRECTION     = 0,
    parameter int          ARENA_LEFT    = 351,
    parameter int          ARENA_RIGHT   = 671,
    parameter int          LANE_A_TOP    = 417,
    parameter int          LANE_A_BOTTOM = 617,
    parameter int          LANE_B_TOP    = 317,
    parameter int          LANE_B_BOTTOM = 517,
    parameter logic [11:0] COLOR         = 12'hfff
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic [11:0] rgb_in,
    input  logic        menu_on,
    input  logic        play_selected,
    input  logic [3:0]  selected,
    input  logic        done_in,
    output logic [11:0] rgb_out,
    output logic [11:0] obstacle_x,
    output logic [11:0] obstacle_y,
    output logic        done
);
    localparam logic [11:0] AL        = 12'(ARENA_LEFT);
    localparam logic [11:0] AR        = 12'(ARENA_RIGHT);
    localparam logic [11:0] SPAWN_R   = 12'(ARENA_RIGHT - PILLAR_WIDTH + 1);
    localparam logic [11:0] W_M1      = 12'(PILLAR_WIDTH - 1);
    localparam logic [11:0] STEP      = 12'(DX);
    localparam logic [11:0] A_TOP     = 12'(LANE_A_TOP);
    localparam logic [11:0] A_BOT     = 12'(LANE_A_BOTTOM);
    localparam logic [11:0] B_TOP     = 12'(LANE_B_TOP);
    localparam logic [11:0] B_BOT     = 12'(LANE_B_BOTTOM);
    localparam logic [23:0] TICK_LAST = 24'(FRAME_DIV - 1);
    localparam logic [7:0]  WAVES_W   = 8'(WAVES);

    typedef enum logic {IDLE, DRAW} state_t;

    function automatic logic [11:0] init_left(input int i);
        if (DIRECTION == 0) return 12'(ARENA_RIGHT - PILLAR_WIDTH + 1 + i * SPACING);
        else                return 12'(ARENA_LEFT - i * SPACING);
    endfunction

    state_t                  state_q, state_d;
    logic [23:0]             tick_q, tick_d;
    logic [7:0]              wave_q, wave_d;
    logic [7:0]              nresp;
    logic [11:0]             left_q [PILLAR_COUNT];
    logic [11:0]             left_d [PILLAR_COUNT];
    logic [PILLAR_COUNT-1:0] lane_q, lane_d;
    logic [11:0]             rgb_q, rgb_d, ox_q, ox_d, oy_q, oy_d;
    logic                    done_q, done_d;
    logic                    hit;

    // Off-arena parts of a pillar are clipped by the arena bounds check.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < PILLAR_COUNT; i++) begin
            if (hcount_in >= left_q[i] && hcount_in <= left_q[i] + W_M1 &&
                hcount_in >= AL && hcount_in <= AR &&
                (lane_q[i] ? (vcount_in >= B_TOP && vcount_in <= B_BOT)
                           : (vcount_in >= A_TOP && vcount_in <= A_BOT)))
                hit = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        wave_d  = wave_q;
        left_d  = left_q;
        lane_d  = lane_q;
        nresp   = 8'd0;
        done_d  = 1'b0;
        rgb_d   = rgb_in;
        ox_d    = 12'd0;
        oy_d    = 12'd0;
        case (state_q)
            IDLE: begin
                if (done_in && play_selected && selected == SELECT_CODE) begin
                    state_d = DRAW;
                    tick_d  = 24'd0;
                    wave_d  = 8'd0;
                    for (int i = 0; i < PILLAR_COUNT; i++) begin
                        left_d[i] = init_left(i);
                        lane_d[i] = i[0];
                    end
                end
            end
            DRAW: begin
                if (hit) begin
                    rgb_d = COLOR;
                    ox_d  = hcount_in;
                    oy_d  = vcount_in;
                end
                if (tick_q == TICK_LAST) begin
                    tick_d = 24'd0;
                    for (int i = 0; i < PILLAR_COUNT; i++) begin
                        if (DIRECTION == 0) begin
                            if (left_q[i] <= AL) begin
                                left_d[i] = SPAWN_R;
                                lane_d[i] = ~lane_q[i];
                                nresp     = nresp + 8'd1;
                            end else begin
                                left_d[i] = left_q[i] - STEP;
                            end
                        end else begin
                            if (left_q[i] + W_M1 >= AR) begin
                                left_d[i] = AL;
                                lane_d[i] = ~lane_q[i];
                                nresp     = nresp + 8'd1;
                            end else begin
                                left_d[i] = left_q[i] + STEP;
                            end
                        end
                    end
                    wave_d = wave_q + nresp;
                end else begin
                    tick_d = tick_q + 24'd1;
                end
                // Completion takes priority over an abort in the same cycle.
                if (wave_q >= WAVES_W) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (menu_on || !play_selected) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= 24'd0;
            wave_q  <= 8'd0;
            for (int i = 0; i < PILLAR_COUNT; i++) begin
                left_q[i] <= init_left(i);
                lane_q[i] <= i[0];
            end
            rgb_q  <= 12'd0;
            ox_q   <= 12'd0;
            oy_q   <= 12'd0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            wave_q  <= wave_d;
            left_q  <= left_d;
            lane_q  <= lane_d;
            rgb_q   <= rgb_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            done_q  <= done_d;
        end
    end

    assign rgb_out    = rgb_q;
    assign obstacle_x = ox_q;
    assign obstacle_y = oy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_pillars_multi_obstacle.sv
// Three differently-parameterised instances share one stimulus stream; each is armed by its own select code
// and compared every cycle against a pillar-list reference model, plus directed pixel checks.
module tb_pillars_multi_obstacle;
    localparam int W = 21, AL = 351, AR = 671;
    localparam int P_SEL [3] = '{0, 1, 2};
    localparam int P_PC  [3] = '{2, 1, 2};
    localparam int P_SP  [3] = '{160, 160, 0};
    localparam int P_FD  [3] = '{4, 2, 2};
    localparam int P_WV  [3] = '{10, 2, 2};
    localparam int P_DIR [3] = '{0, 0, 1};

    logic        clk = 1'b0;
    logic        rst, menu_on, play_sel, done_in;
    logic [11:0] hcount, vcount, rgb_in;
    logic [3:0]  selected;
    logic [11:0] rgb_o [3];
    logic [11:0] x_o [3];
    logic [11:0] y_o [3];
    logic        done_o [3];

    int checks = 0, errors = 0;

    int          m_draw [3], m_tick [3], m_wave [3], m_ticks [3];
    int          m_left [3][4];
    int          m_lane [3][4];
    logic [11:0] exp_rgb [3], exp_x [3], exp_y [3];
    logic        exp_done [3];

    always #5 clk = ~clk;

    pillars_multi_obstacle #(.SELECT_CODE(4'd0), .PILLAR_COUNT(2), .SPACING(160), .FRAME_DIV(4),
        .WAVES(10), .DIRECTION(0)) dut_a (
        .clk(clk), .rst(rst), .hcount_in(hcount), .vcount_in(vcount), .rgb_in(rgb_in),
        .menu_on(menu_on), .play_selected(play_sel), .selected(selected), .done_in(done_in),
        .rgb_out(rgb_o[0]), .obstacle_x(x_o[0]), .obstacle_y(y_o[0]), .done(done_o[0]));

    pillars_multi_obstacle #(.SELECT_CODE(4'd1), .PILLAR_COUNT(1), .SPACING(160), .FRAME_DIV(2),
        .WAVES(2), .DIRECTION(0)) dut_b (
        .clk(clk), .rst(rst), .hcount_in(hcount), .vcount_in(vcount), .rgb_in(rgb_in),
        .menu_on(menu_on), .play_selected(play_sel), .selected(selected), .done_in(done_in),
        .rgb_out(rgb_o[1]), .obstacle_x(x_o[1]), .obstacle_y(y_o[1]), .done(done_o[1]));

    pillars_multi_obstacle #(.SELECT_CODE(4'd2), .PILLAR_COUNT(2), .SPACING(0), .FRAME_DIV(2),
        .WAVES(2), .DIRECTION(1)) dut_c (
        .clk(clk), .rst(rst), .hcount_in(hcount), .vcount_in(vcount), .rgb_in(rgb_in),
        .menu_on(menu_on), .play_selected(play_sel), .selected(selected), .done_in(done_in),
        .rgb_out(rgb_o[2]), .obstacle_x(x_o[2]), .obstacle_y(y_o[2]), .done(done_o[2]));

    function automatic bit m_hit(input int k, input int h, input int v);
        bit r = 1'b0;
        for (int i = 0; i < P_PC[k]; i++) begin
            int top = m_lane[k][i] ? 317 : 417;
            int bot = m_lane[k][i] ? 517 : 617;
            if (h >= m_left[k][i] && h <= m_left[k][i] + W - 1 && h >= AL && h <= AR &&
                v >= top && v <= bot) r = 1'b1;
        end
        return r;
    endfunction

    task automatic init_pos(input int k);
        for (int i = 0; i < P_PC[k]; i++) begin
            m_lane[k][i] = i % 2;
            m_left[k][i] = (P_DIR[k] == 0) ? AR - W + 1 + i * P_SP[k] : AL - i * P_SP[k];
        end
    endtask

    task automatic model_step(input int k);
        int nd;
        if (rst) begin
            m_draw[k] = 0; m_tick[k] = 0; m_wave[k] = 0; m_ticks[k] = 0;
            init_pos(k);
            exp_rgb[k] = '0; exp_x[k] = '0; exp_y[k] = '0; exp_done[k] = 1'b0;
        end else begin
            nd = m_draw[k];
            if (m_draw[k] != 0 && m_hit(k, int'(hcount), int'(vcount))) begin
                exp_rgb[k] = 12'hfff; exp_x[k] = hcount; exp_y[k] = vcount;
            end else begin
                exp_rgb[k] = rgb_in; exp_x[k] = '0; exp_y[k] = '0;
            end
            exp_done[k] = 1'b0;
            if (m_draw[k] == 0) begin
                if (done_in && play_sel && int'(selected) == P_SEL[k]) begin
                    nd = 1; m_tick[k] = 0; m_wave[k] = 0; m_ticks[k] = 0;
                    init_pos(k);
                end
            end else begin
                if (m_wave[k] >= P_WV[k]) begin
                    exp_done[k] = 1'b1; nd = 0;
                end else if (menu_on || !play_sel) begin
                    nd = 0;
                end
                if (m_tick[k] == P_FD[k] - 1) begin
                    m_tick[k] = 0;
                    m_ticks[k]++;
                    for (int i = 0; i < P_PC[k]; i++) begin
                        if (P_DIR[k] == 0 ? m_left[k][i] <= AL : m_left[k][i] + W - 1 >= AR) begin
                            m_left[k][i] = (P_DIR[k] == 0) ? AR - W + 1 : AL;
                            m_lane[k][i] = 1 - m_lane[k][i];
                            m_wave[k]++;
                        end else begin
                            m_left[k][i] += (P_DIR[k] == 0) ? -1 : 1;
                        end
                    end
                end else begin
                    m_tick[k]++;
                end
            end
            m_draw[k] = nd;
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) model_step(k);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("dut%0d rgb_out", k), 32'(rgb_o[k]), 32'(exp_rgb[k]));
            chk($sformatf("dut%0d obstacle_x", k), 32'(x_o[k]), 32'(exp_x[k]));
            chk($sformatf("dut%0d obstacle_y", k), 32'(y_o[k]), 32'(exp_y[k]));
            chk($sformatf("dut%0d done", k), 32'(done_o[k]), 32'(exp_done[k]));
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_model();
    endtask

    task automatic pix(input int h, input int v, input logic [11:0] c);
        hcount = 12'(h); vcount = 12'(v); rgb_in = c;
    endtask

    task automatic rnd_pix();
        pix(int'($urandom_range(340, 840)), int'($urandom_range(300, 640)), 12'($urandom));
    endtask

    initial begin
        int pulses;
        bit seen;
        rst = 1'b1; menu_on = 1'b0; play_sel = 1'b0; done_in = 1'b0; selected = 4'd0;
        rnd_pix();
        for (int n = 0; n < 3; n++) begin
            done_in = 1'($urandom); play_sel = 1'($urandom); selected = 4'($urandom);
            rnd_pix();
            cyc();
        end
        chk("reset rgb_out", 32'(rgb_o[0]), 32'h0);
        chk("reset obstacle_x", 32'(x_o[0]), 32'h0);
        chk("reset done", 32'(done_o[0]), 32'h0);

        rst = 1'b0; done_in = 1'b0; play_sel = 1'b0; selected = 4'd0;
        pix(0, 0, 12'h123);
        cyc();
        chk("post-reset passthrough", 32'(rgb_o[0]), 32'h123);

        // Instance A: default geometry, FRAME_DIV=4
        play_sel = 1'b1; selected = 4'd0; done_in = 1'b1;
        rnd_pix(); cyc();
        done_in = 1'b0;
        pix(660, 500, 12'h0a5); cyc();
        chk("A first pixel rgb", 32'(rgb_o[0]), 32'hfff);
        chk("A first pixel x", 32'(x_o[0]), 32'd660);
        chk("A first pixel y", 32'(y_o[0]), 32'd500);
        pix(660, 400, 12'h456); cyc();
        chk("A off-lane rgb", 32'(rgb_o[0]), 32'h456);
        chk("A off-lane x", 32'(x_o[0]), 32'd0);
        pix(811, 500, 12'h789); cyc();
        chk("A clipped pillar1", 32'(rgb_o[0]), 32'h789);

        for (int n = 0; n < 2000 && m_ticks[0] < 300; n++) begin rnd_pix(); cyc(); end
        pix(351, 500, 12'h111); cyc();
        chk("A left edge at 351", 32'(rgb_o[0]), 32'hfff);
        pix(372, 500, 12'h222); cyc();
        chk("A past right edge", 32'(rgb_o[0]), 32'h222);
        for (int n = 0; n < 20 && m_ticks[0] < 301; n++) begin rnd_pix(); cyc(); end
        pix(660, 350, 12'h333); cyc();
        chk("A respawn lane B drawn", 32'(rgb_o[0]), 32'hfff);
        chk("A respawn y", 32'(y_o[0]), 32'd350);
        pix(660, 600, 12'h444); cyc();
        chk("A respawn lane A empty", 32'(rgb_o[0]), 32'h444);

        menu_on = 1'b1; rnd_pix(); cyc();
        menu_on = 1'b0;
        pix(660, 350, 12'h321); cyc();
        chk("A abort passthrough", 32'(rgb_o[0]), 32'h321);
        chk("A abort no done", 32'(done_o[0]), 32'h0);

        // Instance B: plain completion after two respawns
        selected = 4'd1; done_in = 1'b1; rnd_pix(); cyc();
        done_in = 1'b0;
        pulses = 0;
        for (int n = 0; n < 1400; n++) begin
            rnd_pix(); cyc();
            if (done_o[1] === 1'b1) pulses++;
        end
        chk("B done pulse count", 32'(pulses), 32'd1);
        pix(660, 500, 12'h5a5); cyc();
        chk("B idle passthrough", 32'(rgb_o[1]), 32'h5a5);

        // Instance B again: abort arriving together with completion
        done_in = 1'b1; rnd_pix(); cyc();
        done_in = 1'b0;
        for (int n = 0; n < 1400 && m_wave[1] < 2; n++) begin rnd_pix(); cyc(); end
        menu_on = 1'b1; rnd_pix(); cyc();
        chk("B completion beats abort", 32'(done_o[1]), 32'h1);
        menu_on = 1'b0; rnd_pix(); cyc();
        chk("B done single cycle", 32'(done_o[1]), 32'h0);

        // Instance C: left-to-right, both pillars stacked so they respawn together
        selected = 4'd2; done_in = 1'b1; rnd_pix(); cyc();
        done_in = 1'b0;
        pix(351, 400, 12'h600); cyc();
        chk("C pillar1 lane B at 351", 32'(rgb_o[2]), 32'hfff);
        pix(351, 600, 12'h601); cyc();
        chk("C pillar0 lane A at 351", 32'(rgb_o[2]), 32'hfff);
        pix(351, 600, 12'h602); cyc();
        chk("C moved right", 32'(rgb_o[2]), 32'h602);
        pix(372, 600, 12'h603); cyc();
        chk("C new right edge", 32'(rgb_o[2]), 32'hfff);
        seen = 1'b0;
        for (int n = 0; n < 700 && !seen; n++) begin
            rnd_pix(); cyc();
            if (done_o[2] === 1'b1) seen = 1'b1;
        end
        chk("C double respawn completes", 32'(seen), 32'h1);

        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 99) == 0);
            done_in  = ($urandom_range(0, 19) == 0);
            menu_on  = ($urandom_range(0, 49) == 0);
            play_sel = ($urandom_range(0, 29) != 0);
            selected = 4'($urandom_range(0, 3));
            rnd_pix();
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
